// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Only a 32-bit datapath is supported.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int          ITERATIONS = 32;
  localparam int          CNT_W      = 6;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;
  localparam logic [31:0] NEG_ONE    = 32'hFFFF_FFFF;

  // Unsigned magnitude of a two's-complement word; INT_MIN maps to 0x80000000.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract
// the divisor from the remainder, and keep the difference when it is non-negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] i_rq,
  input  logic [WIDTH-1:0]   i_divisor,
  output logic [2*WIDTH-1:0] o_rq
);

  logic [2*WIDTH-1:0] w_shifted;
  logic [WIDTH:0]     w_trial;

  assign w_shifted = {i_rq[2*WIDTH-2:0], 1'b0};
  // Extra top bit acts as the borrow: set means the trial went negative.
  assign w_trial   = {1'b0, w_shifted[2*WIDTH-1:WIDTH]} - {1'b0, i_divisor};

  always_comb begin
    o_rq = w_shifted;
    if (!w_trial[WIDTH]) begin
      o_rq = {w_trial[WIDTH-1:0], w_shifted[WIDTH-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply (radix-2 Booth) / divide (restoring on magnitudes)
// with a fixed 33-cycle start-to-result latency and a one-cycle ready pulse.
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);
  import multdiv_pkg::*;

  localparam logic [CNT_W-1:0] TERM = CNT_W'(ITERATIONS);

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_mcand;
  logic [2*WIDTH:0]     r_mult;
  logic [2*WIDTH-1:0]   r_rq;
  logic [WIDTH-1:0]     r_dvs_mag;
  logic                 r_neg;
  logic                 r_div_exc;
  logic [WIDTH-1:0]     r_result;
  logic                 r_exc;
  logic                 r_rdy;

  logic [WIDTH:0]       w_hi_ext;
  logic [WIDTH:0]       w_mcand_ext;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH:0]     w_mult_next;
  logic [2*WIDTH-1:0]   w_product;
  logic                 w_mult_exc;
  logic [2*WIDTH-1:0]   w_rq_next;
  logic [WIDTH-1:0]     w_quo_signed;

  // Accumulator is widened by one bit so subtracting INT_MIN cannot overflow.
  assign w_hi_ext    = {r_mult[2*WIDTH], r_mult[2*WIDTH:WIDTH+1]};
  assign w_mcand_ext = {r_mcand[WIDTH-1], r_mcand};

  always_comb begin
    w_sum = w_hi_ext;
    case (r_mult[1:0])
      2'b01:   w_sum = w_hi_ext + w_mcand_ext;
      2'b10:   w_sum = w_hi_ext - w_mcand_ext;
      default: w_sum = w_hi_ext;
    endcase
  end

  assign w_mult_next  = {w_sum, r_mult[WIDTH:1]};
  assign w_product    = r_mult[2*WIDTH:1];
  assign w_mult_exc   = (w_product[2*WIDTH-1:WIDTH] != {WIDTH{w_product[WIDTH-1]}});
  assign w_quo_signed = r_neg ? (~r_rq[WIDTH-1:0] + 1'b1) : r_rq[WIDTH-1:0];

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .i_rq      (r_rq),
    .i_divisor (r_dvs_mag),
    .o_rq      (w_rq_next)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_mult    <= '0;
      r_rq      <= '0;
      r_dvs_mag <= '0;
      r_neg     <= 1'b0;
      r_div_exc <= 1'b0;
      r_result  <= '0;
      r_exc     <= 1'b0;
      r_rdy     <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (ctrl_MULT || ctrl_DIV) begin
        // Any start pulse (re)launches; MULT takes priority over DIV.
        r_state   <= ctrl_MULT ? MULT : DIV;
        r_cnt     <= '0;
        r_mcand   <= data_operandA;
        r_mult    <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
        r_rq      <= {{WIDTH{1'b0}}, mag32(data_operandA)};
        r_dvs_mag <= mag32(data_operandB);
        r_neg     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        r_div_exc <= (data_operandB == '0) ||
                     ((data_operandA == INT_MIN) && (data_operandB == NEG_ONE));
      end else begin
        case (r_state)
          MULT: begin
            if (r_cnt == TERM) begin
              r_result <= w_mult_exc ? '0 : w_product[WIDTH-1:0];
              r_exc    <= w_mult_exc;
              r_rdy    <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_mult <= w_mult_next;
              r_cnt  <= r_cnt + 1'b1;
            end
          end
          DIV: begin
            if (r_cnt == TERM) begin
              r_result <= r_div_exc ? '0 : w_quo_signed;
              r_exc    <= r_div_exc;
              r_rdy    <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_rq  <= w_rq_next;
              r_cnt <= r_cnt + 1'b1;
            end
          end
          DONE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed cases plus randomized operands
// compared against a plain-arithmetic reference model.
module tb_multdiv_unit;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int total = 0;
  int bad   = 0;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: signed arithmetic straight from the result/exception rules.
  function automatic void model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    int     sa;
    int     sb;
    int     lo;
    longint p;
    sa = a;
    sb = b;
    if (!is_div) begin
      p  = longint'(sa) * longint'(sb);
      lo = int'(p[31:0]);
      e  = (p != longint'(lo));
      r  = e ? 32'd0 : p[31:0];
    end else if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
      e = 1'b1;
      r = 32'd0;
    end else begin
      e = 1'b0;
      r = sa / sb;
    end
  endfunction

  // Drive a start pulse now; it is sampled at the next rising edge (E0).
  task automatic start_op(input bit is_div, input logic [31:0] a, input logic [31:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = !is_div;
    ctrl_DIV      = is_div;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Called 1 time unit after E0; returns 1 time unit after the edge that raised RDY.
  task automatic finish_op(input bit is_div, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    logic        ee;
    int          n;
    model(is_div, a, b, er, ee);
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!data_resultRDY && n < 60);
    chk("latency", n, 33);
    chk("result", data_result, er);
    chk("exception", data_exception, ee);
    $display("op=%s a=%h b=%h result=%h exc=%b exp=%h/%b lat=%0d",
             is_div ? "DIV " : "MULT", a, b, data_result, data_exception, er, ee, n);
  endtask

  task automatic do_op(input bit is_div, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    start_op(is_div, a, b);
    finish_op(is_div, a, b);
    @(posedge clock);
    #1;
    chk("rdy_one_cycle", data_resultRDY, 1'b0);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'd0;
      1:       v = 32'h8000_0000;
      2:       v = 32'hFFFF_FFFF;
      3:       v = $urandom_range(0, 300);
      4:       v = -$urandom_range(1, 300);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int          rdy_cnt;
    int          rdy_at;
    logic [31:0] ra;
    logic [31:0] rb;
    bit          rop;

    reset = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_result", data_result, 32'd0);
    chk("reset_exc", data_exception, 1'b0);
    chk("reset_rdy", data_resultRDY, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    // Directed cases from the result/exception rules.
    do_op(1'b0, 32'd7, 32'hFFFF_FFFD);
    do_op(1'b0, 32'h0001_0000, 32'h0001_0000);
    do_op(1'b1, -32'sd20, 32'd3);
    do_op(1'b1, 32'd100, 32'd7);
    do_op(1'b1, 32'd55, 32'd0);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(1'b0, 32'h8000_0000, 32'd1);

    // Restart: MULT aborted by DIV nine edges after its start.
    @(negedge clock);
    start_op(1'b0, 32'd6, 32'd7);
    repeat (8) @(posedge clock);
    @(negedge clock);
    data_operandA = 32'd81;
    data_operandB = 32'd9;
    ctrl_DIV = 1'b1;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    rdy_cnt = 0;
    rdy_at  = 0;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        rdy_cnt++;
        if (rdy_at == 0) begin
          rdy_at = i;
          chk("restart_result", data_result, 32'd9);
        end
      end
    end
    chk("restart_rdy_count", rdy_cnt, 1);
    chk("restart_rdy_at", rdy_at, 33);
    $display("op=RESTART mult 6x7 -> div 81/9 rdy_count=%0d rdy_at=%0d result=%h",
             rdy_cnt, rdy_at, data_result);

    // Back-to-back: next start issued during the DONE cycle.
    @(negedge clock);
    start_op(1'b0, 32'd1000, -32'sd3);
    finish_op(1'b0, 32'd1000, -32'sd3);
    start_op(1'b1, -32'sd99, -32'sd4);
    chk("b2b_rdy_dropped", data_resultRDY, 1'b0);
    finish_op(1'b1, -32'sd99, -32'sd4);
    @(posedge clock);
    #1;

    // Reset mid-multiply: outputs clear at once and no RDY follows.
    @(negedge clock);
    start_op(1'b0, 32'd5, 32'd9);
    repeat (14) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("midreset_result", data_result, 32'd0);
    chk("midreset_exc", data_exception, 1'b0);
    chk("midreset_rdy", data_resultRDY, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    rdy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) rdy_cnt++;
    end
    chk("midreset_no_rdy", rdy_cnt, 0);
    $display("op=RESET mid-multiply rdy_after_reset=%0d", rdy_cnt);
    do_op(1'b0, 32'd3, 32'd4);

    // Randomized operands with edge values mixed in.
    for (int k = 0; k < 40; k++) begin
      rop = $urandom_range(0, 1);
      ra  = pick_operand();
      rb  = pick_operand();
      do_op(rop, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
